// File: rtl/queue_reader_pkg.sv
// Shared constants and types for the queue reader slice.
// Holds the default word width and the output buffer depth.
package queue_reader_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/queue_reader_skid_buf2.sv
// Two-entry in-order output buffer for the queue reader.
// Head is always the oldest word; flush empties it, reset also clears data.
module skid_buf2
  import queue_reader_pkg::*;
#(
  parameter int DW = DEFAULT_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  input  logic          flush,
  output occ_t          occ,
  output logic [DW-1:0] head
);

  logic [DW-1:0] tail;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      unique case (1'b1)
        wr && !pop: begin
          if (occ == 2'd0) head <= wr_data;
          else tail <= wr_data;
          occ <= occ + 2'd1;
        end
        !wr && pop: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        // Pop and write together: occupancy holds, order kept.
        wr && pop: begin
          if (occ == 2'd1) begin
            head <= wr_data;
          end else begin
            head <= tail;
            tail <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/queue_reader.sv
// Turns a 1-cycle-latency queue read port into a valid/ready stream.
// Define QUEUE_READER_STATS_EN to add the drained-word counter.
module queue_reader
  import queue_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
`ifdef QUEUE_READER_STATS_EN
  ,
  parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  q_empty,
  input  logic [DATA_WIDTH-1:0] q_data,
  output logic                  q_deq,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef QUEUE_READER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  drained
`endif
);

  logic       inflight;
  occ_t       occ;
  logic       pop;
  logic       pop_eff;
  logic [2:0] load;

  assign pop     = m_valid && m_ready;
  assign pop_eff = pop && !flush;
  assign m_valid = (occ != 2'd0);

  // Slots committed after this cycle; issue only if one stays free.
  assign load  = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign q_deq = !reset && !q_empty && !flush
               && (load < 3'(BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) inflight <= 1'b0;
    else inflight <= q_deq;
  end

  skid_buf2 #(
    .DW(DATA_WIDTH)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .wr     (inflight),
    .wr_data(q_data),
    .pop    (pop_eff),
    .flush  (flush),
    .occ    (occ),
    .head   (m_data)
  );

`ifdef QUEUE_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) drained <= '0;
    else if (pop_eff) drained <= drained + 1'b1;
  end
`endif

endmodule

// File: tb/tb_queue_reader.sv
// Scoreboard bench for queue_reader: queue model plus expected-word queue.
// Build with QUEUE_READER_STATS_EN to also exercise the drained counter.
module tb_queue_reader;
  import queue_reader_pkg::*;

  localparam int DW = DEFAULT_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          q_empty;
  logic [DW-1:0] q_data;
  logic          q_deq;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef QUEUE_READER_STATS_EN
  logic [3:0]    drained;
`endif

  always #5 clk = ~clk;

  queue_reader #(
    .DATA_WIDTH(DW)
`ifdef QUEUE_READER_STATS_EN
    ,
    .CNT_WIDTH(4)
`endif
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .q_empty(q_empty),
    .q_data (q_data),
    .q_deq  (q_deq),
    .flush  (flush),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data)
`ifdef QUEUE_READER_STATS_EN
    ,
    .drained(drained)
`endif
  );

  logic [DW-1:0] qmem[$];
  logic [DW-1:0] exp_q[$];

  int tests, fails;
  int cyc, pops, deq_cnt;
  int first_deq, first_valid, first_pop, last_pop;
  logic          hold_prev;
  logic [DW-1:0] hold_data;
  logic [DW-1:0] last_data;

  task automatic push(input logic [DW-1:0] w);
    qmem.push_back(w);
    q_empty = 1'b0;
  endtask

  task automatic clr();
    cyc = 0; pops = 0; deq_cnt = 0;
    first_deq = -1; first_valid = -1;
    first_pop = -1; last_pop = -1;
  endtask

  // One clock: sample at mid-cycle, score pops, then model the queue.
  task automatic step();
    logic deq, v, r;
    logic [DW-1:0] d, e;
    #1;
    deq = q_deq; v = m_valid; r = m_ready; d = m_data;
    if (deq) begin
      deq_cnt++;
      if (first_deq < 0) first_deq = cyc;
    end
    if (v && first_valid < 0) first_valid = cyc;
    if (q_empty) begin
      tests++;
      if (deq !== 1'b0) begin
        fails++;
        $display("FAIL deq_while_empty: q_deq=%0b required 0 cyc %0d",
                 deq, cyc);
      end
    end
    if (hold_prev && !flush && !reset) begin
      tests++;
      if (v !== 1'b1 || d !== hold_data) begin
        fails++;
        $display("FAIL hold: valid=%0b data=%h required 1 %h",
                 v, d, hold_data);
      end
    end
    if (v && r && !flush && !reset) begin
      tests++;
      pops++;
      last_pop = cyc;
      last_data = d;
      if (first_pop < 0) first_pop = cyc;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_word: data=%h required none", d);
      end else begin
        e = exp_q.pop_front();
        if (d !== e) begin
          fails++;
          $display("FAIL order: data=%h required %h", d, e);
        end
      end
    end
    hold_prev = v && !r && !flush && !reset;
    hold_data = d;
    if (flush || reset) exp_q.delete();
    @(posedge clk);
    #1;
    if (deq && qmem.size() > 0) begin
      q_data = qmem.pop_front();
      exp_q.push_back(q_data);
    end
    q_empty = (qmem.size() == 0);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    #1;
    tests++;
    if (m_valid !== 1'b0 || m_data !== '0 || q_deq !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: v=%0b d=%h deq=%0b required 0 0 0",
               m_valid, m_data, q_deq);
    end
`ifdef QUEUE_READER_STATS_EN
    tests++;
    if (drained !== 4'd0) begin
      fails++;
      $display("FAIL reset_drained: %0d required 0", drained);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_stream();
    clr();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(DW'(32'h11 + i));
    repeat (14) step();
    tests++;
    if (pops != 8) begin
      fails++;
      $display("FAIL stream_count: %0d required 8", pops);
    end
    tests++;
    if (first_valid - first_deq != 2) begin
      fails++;
      $display("FAIL stream_latency: %0d required 2",
               first_valid - first_deq);
    end
    tests++;
    if (last_pop - first_pop != 7) begin
      fails++;
      $display("FAIL stream_rate: span %0d required 7",
               last_pop - first_pop);
    end
  endtask

  task automatic test_backpressure();
    clr();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(DW'(32'h11 + i));
    repeat (10) step();
    tests++;
    if (deq_cnt != 2) begin
      fails++;
      $display("FAIL bp_deq: %0d pulses required 2", deq_cnt);
    end
    #1;
    tests++;
    if (m_valid !== 1'b1 || m_data !== DW'(32'h11)) begin
      fails++;
      $display("FAIL bp_head: v=%0b d=%h required 1 11",
               m_valid, m_data);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 30 && pops < 5; i++) step();
    repeat (3) step();
    tests++;
    if (pops != 5 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL bp_drain: pops=%0d left=%0d required 5 0",
               pops, exp_q.size());
    end
  endtask

  task automatic test_empty_boundary();
    clr();
    for (int i = 0; i < 6; i++) push(DW'(32'h21 + i));
    for (int i = 0; i < 40; i++) begin
      m_ready = (i % 2 == 0);
      step();
    end
    tests++;
    if (pops != 6 || deq_cnt != 6 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL empty_drain: pops=%0d deq=%0d required 6 6",
               pops, deq_cnt);
    end
  endtask

  task automatic test_flush();
    clr();
    m_ready = 1'b0;
    push(DW'(32'h30)); push(DW'(32'h31)); push(DW'(32'h40));
    step(); step();
    tests++;
    if (deq_cnt != 2) begin
      fails++;
      $display("FAIL flush_setup: deq=%0d required 2", deq_cnt);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_valid: %0b required 0", m_valid);
    end
    m_ready = 1'b1;
    repeat (6) step();
    tests++;
    if (pops != 1 || last_data !== DW'(32'h40)) begin
      fails++;
      $display("FAIL flush_next: pops=%0d d=%h required 1 40",
               pops, last_data);
    end
  endtask

  task automatic test_reset_midstream();
    clr();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(DW'(32'h50 + i));
    step(); step();
    reset = 1'b1;
    step();
    #1;
    tests++;
    if (q_deq !== 1'b0) begin
      fails++;
      $display("FAIL rst_deq: %0b required 0", q_deq);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (m_valid !== 1'b0 || m_data !== '0 || q_deq !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid: v=%0b d=%h deq=%0b required 0 0 1",
               m_valid, m_data, q_deq);
    end
`ifdef QUEUE_READER_STATS_EN
    tests++;
    if (drained !== 4'd0) begin
      fails++;
      $display("FAIL rst_drained: %0d required 0", drained);
    end
`endif
    m_ready = 1'b1;
    for (int i = 0; i < 20 && pops < 2; i++) step();
    repeat (3) step();
    tests++;
    if (pops != 2 || last_data !== DW'(32'h53)) begin
      fails++;
      $display("FAIL rst_restart: pops=%0d d=%h required 2 53",
               pops, last_data);
    end
  endtask

`ifdef QUEUE_READER_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    step();
    reset = 1'b0;
    clr();
    m_ready = 1'b1;
    for (int i = 0; i < 18; i++) push(DW'(32'h60 + i));
    for (int i = 0; i < 60 && pops < 18; i++) step();
    repeat (2) step();
    #1;
    tests++;
    if (drained !== 4'd2) begin
      fails++;
      $display("FAIL stats_wrap: %0d required 2", drained);
    end
    m_ready = 1'b0;
    push(DW'(32'h7A));
    repeat (3) step();
    m_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    tests++;
    if (drained !== 4'd2 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL stats_flush: drained=%0d v=%0b required 2 0",
               drained, m_valid);
    end
  endtask
`endif

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; flush = 1'b0; m_ready = 1'b0;
    q_empty = 1'b1; q_data = '0;
    hold_prev = 1'b0; hold_data = '0; last_data = '0;
    clr();
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_boundary();
    test_flush();
    test_reset_midstream();
`ifdef QUEUE_READER_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
